flex_counter_modal: RTL and testbench
=====================================

FLEX_COUNTER_MODAL -- requirements
Module: flex_counter_modal

Interface
REQ-001 SHALL have parameter NUM_CNT_BITS, default 4, counter/terminal width (legal 2..32).
REQ-002 SHALL have parameter WRAP_TO_ONE, default 1, up-count wrap target: 1 when set, 0 when clear.
REQ-003 SHALL use one clock, clk; reset n_rst is asynchronous, active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 n_rst  input  1  async active-low reset.
REQ-006 clear  input  1  sync clear to zero.
REQ-007 load  input  1  sync load of load_val.
REQ-008 load_val  input  NUM_CNT_BITS  value taken on load.
REQ-009 count_enable  input  1  advance one step this cycle.
REQ-010 count_dir  input  1  0 = up, 1 = down.
REQ-011 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
REQ-012 rollover_val  input  NUM_CNT_BITS  upper terminal value.
REQ-013 count_out  output  NUM_CNT_BITS  registered count.
REQ-014 rollover_flag  output  1  registered; high exactly while count_out equals the active terminal.
REQ-015 wrap_pulse  output  1  registered; one-cycle pulse on the cycle after a wrap step.
REQ-016 done  output  1  registered; one-shot completion, sticky.

Function
REQ-017 Priority per edge SHALL be: n_rst, then clear, then load, then count_enable, else hold.
REQ-018 Active terminal SHALL be rollover_val when count_dir=0, 0 when count_dir=1.
REQ-019 Up step: count_out < rollover_val -> count_out+1; count_out >= rollover_val -> wrap target (wrap mode), hold (saturate, one-shot).
REQ-020 Down step: count_out > 0 -> count_out-1; count_out == 0 -> rollover_val (wrap mode), hold (saturate, one-shot).
REQ-021 Wrap target, up direction: 1 if WRAP_TO_ONE else 0; if rollover_val == 0, target SHALL be 0.
REQ-022 Arithmetic: unsigned, NUM_CNT_BITS wide; count_out SHALL never wrap through 2^N-1 <-> 0 except via REQ-019/020.
REQ-023 rollover_flag SHALL be computed from next count and next direction and registered with count_out: zero latency relative to count_out, no one-cycle lag.
REQ-024 wrap_pulse SHALL be 1 for exactly one cycle after each REQ-019/020 wrap step, else 0; never set by load/clear.
REQ-025 One-shot: enabled step reaching the terminal SHALL set done on the same edge; while done=1, count_enable SHALL be ignored.
REQ-026 done SHALL clear only on clear, load, or reset; mode change alone SHALL NOT clear it.
REQ-027 load SHALL set count_out=load_val, recompute rollover_flag from load_val, clear wrap_pulse and done.
REQ-028 clear SHALL set count_out=0, wrap_pulse=0, done=0; rollover_flag = (terminal for current dir == 0).
REQ-029 Direction or rollover_val change mid-count SHALL take effect on the next edge with no extra state; rollover_flag follows REQ-023 after that edge.
REQ-030 Loaded value above rollover_val, up direction: next enabled step SHALL apply REQ-019 (wrap or hold), not increment.

Reset
REQ-031 On n_rst low, asynchronously: count_out=0, rollover_flag=0, wrap_pulse=0, done=0.
REQ-032 Reset mid-count or mid-one-shot SHALL discard all state; first post-reset edge SHALL obey REQ-017 normally.

Verification
REQ-033 N=4, WRAP_TO_ONE=1, wrap, up, rollover_val=5, enable 7 cycles from 0 -> 1,2,3,4,5,1,2; rollover_flag high only at 5; wrap_pulse high the cycle count shows 1 after 5.
REQ-034 Down, wrap, rollover_val=3, load 1, enable 3 cycles -> 0,3,2; rollover_flag high at 0; wrap_pulse once, with count=3.
REQ-035 Saturate, up, rollover_val=15, enable 20 cycles -> holds at 15, rollover_flag stays 1, wrap_pulse never set.
REQ-036 One-shot, up, rollover_val=2, enable continuously -> 1,2 then hold; done=1 from count=2; load 0 -> done=0, counting resumes.
REQ-037 clear and load and count_enable high same cycle at count=4 -> count_out=0; n_rst low mid-count -> all outputs 0 immediately, before next clk.
REQ-038 Load 9 with rollover_val=5, up, wrap, enable -> count_out=1, wrap_pulse pulses once.

Source files
------------

// File: rtl/flex_counter_modal.sv
// flex_counter_modal: parameterised up/down counter with three terminal behaviours
// (wrap, saturate, one-shot). It has synchronous clear and load, and registered
// rollover, wrap and done status.
module flex_counter_modal #(
    parameter int unsigned NUM_CNT_BITS = 4,
    parameter int unsigned WRAP_TO_ONE  = 1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_dir,
    input  logic [1:0]              mode,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    wrap_pulse,
    output logic                    done
);

    typedef enum logic [1:0] {
        ModeWrap    = 2'b00,
        ModeSat     = 2'b01,
        ModeOneShot = 2'b10,
        ModeWrapAlt = 2'b11
    } mode_e;

    localparam logic [NUM_CNT_BITS-1:0] One = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;
    logic                    wrap_q, wrap_d;
    logic                    done_q, done_d;
    logic [NUM_CNT_BITS-1:0] terminal;
    logic [NUM_CNT_BITS-1:0] wrap_tgt;
    logic                    holds_at_end;
    mode_e                   mode_s;

    assign mode_s = mode_e'(mode);

    // Next-state: clear > load > enabled step > hold; flag derives from the next count
    always_comb begin
        count_d      = count_q;
        wrap_d       = 1'b0;
        done_d       = done_q;
        terminal     = count_dir ? '0 : rollover_val;
        // A zero upper terminal forces the up-wrap target to zero as well
        wrap_tgt     = ((WRAP_TO_ONE != 0) && (rollover_val != '0)) ? One : '0;
        holds_at_end = (mode_s == ModeSat) || (mode_s == ModeOneShot);

        if (clear) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (count_enable && !done_q) begin
            if (!count_dir) begin
                // Values at or above the terminal (e.g. after a load) take the terminal action
                if (count_q < rollover_val) begin
                    count_d = count_q + One;
                end else if (!holds_at_end) begin
                    count_d = wrap_tgt;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - One;
                end else if (!holds_at_end) begin
                    count_d = rollover_val;
                    wrap_d  = 1'b1;
                end
            end
            if ((mode_s == ModeOneShot) && (count_d == terminal)) begin
                done_d = 1'b1;
            end
        end

        flag_d = (count_d == terminal);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;
    assign wrap_pulse    = wrap_q;
    assign done          = done_q;

endmodule

// File: tb/tb_flex_counter_modal.sv
// Self-checking bench for flex_counter_modal: directed scenarios plus randomized traffic
// compared against a behavioural model of the counter rules.
module tb_flex_counter_modal;

    localparam int N    = 4;
    localparam int WRAP = 1;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         load;
    logic [N-1:0] load_val;
    logic         count_enable;
    logic         count_dir;
    logic [1:0]   mode;
    logic [N-1:0] rollover_val;
    logic [N-1:0] count_out;
    logic         rollover_flag;
    logic         wrap_pulse;
    logic         done;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_flag = 0;
    int m_wrap = 0;
    int m_done = 0;

    flex_counter_modal #(
        .NUM_CNT_BITS(N),
        .WRAP_TO_ONE (WRAP)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_dir    (count_dir),
        .mode         (mode),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .wrap_pulse   (wrap_pulse),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count_out), m_cnt);
        check({tag, ".flag"}, int'(rollover_flag), m_flag);
        check({tag, ".wrap"}, int'(wrap_pulse), m_wrap);
        check({tag, ".done"}, int'(done), m_done);
    endtask

    // Model of one rising edge, from the counter's stated rules
    task automatic model_edge();
        int rv, term, nxt, wrapped;
        bit holds;
        rv    = int'(rollover_val);
        term  = count_dir ? 0 : rv;
        holds = (mode == 2'd1) || (mode == 2'd2);
        if (clear) begin
            m_cnt = 0; m_wrap = 0; m_done = 0;
        end else if (load) begin
            m_cnt = int'(load_val); m_wrap = 0; m_done = 0;
        end else if (count_enable && m_done == 0) begin
            wrapped = 0;
            nxt     = m_cnt;
            if (!count_dir) begin
                if (m_cnt < rv) nxt = m_cnt + 1;
                else if (!holds) begin
                    nxt = (rv == 0) ? 0 : WRAP;
                    wrapped = 1;
                end
            end else begin
                if (m_cnt > 0) nxt = m_cnt - 1;
                else if (!holds) begin
                    nxt = rv;
                    wrapped = 1;
                end
            end
            if (mode == 2'd2 && nxt == term) m_done = 1;
            m_cnt  = nxt;
            m_wrap = wrapped;
        end else begin
            m_wrap = 0;
        end
        m_flag = (m_cnt == term) ? 1 : 0;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drv(input bit clr, input bit ld, input int lv, input bit en, input bit dir,
                       input int md, input int rv, input string tag);
        clear        = clr;
        load         = ld;
        load_val     = N'(lv);
        count_enable = en;
        count_dir    = dir;
        mode         = 2'(md);
        rollover_val = N'(rv);
        step(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        m_cnt = 0; m_flag = 0; m_wrap = 0; m_done = 0;
        check_all(tag);
        #1;
        n_rst = 1'b1;
    endtask

    int exp_up[7]   = '{1, 2, 3, 4, 5, 1, 2};
    int exp_wrap[7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        count_enable = 1'b0; count_dir = 1'b0; mode = 2'd0; rollover_val = '0;
        #12;
        check_all("reset");
        @(negedge clk);
        n_rst = 1'b1;

        // Up wrap to one at rollover_val=5
        drv(1, 0, 0, 0, 0, 0, 5, "up_clr");
        for (int i = 0; i < 7; i++) begin
            drv(0, 0, 0, 1, 0, 0, 5, "up_wrap");
            check("up_seq.count", int'(count_out), exp_up[i]);
            check("up_seq.wrap", int'(wrap_pulse), exp_wrap[i]);
        end

        // Down wrap from 1 with rollover_val=3
        drv(0, 1, 1, 0, 1, 0, 3, "dn_load");
        for (int i = 0; i < 3; i++) drv(0, 0, 0, 1, 1, 0, 3, "dn_wrap");

        // Saturate at 15
        drv(1, 0, 0, 0, 0, 1, 15, "sat_clr");
        for (int i = 0; i < 20; i++) drv(0, 0, 0, 1, 0, 1, 15, "sat");
        check("sat.final", int'(count_out), 15);

        // One-shot to 2, then load 0 re-arms; mode change must not clear done
        drv(1, 0, 0, 0, 0, 2, 2, "os_clr");
        for (int i = 0; i < 4; i++) drv(0, 0, 0, 1, 0, 2, 2, "os");
        check("os.done", int'(done), 1);
        drv(0, 0, 0, 1, 0, 0, 2, "os_modechg");
        drv(0, 1, 0, 1, 0, 2, 2, "os_load");
        drv(0, 0, 0, 1, 0, 2, 2, "os_resume");

        // clear beats load beats enable at count 4
        drv(0, 1, 4, 0, 0, 0, 9, "prio_ld");
        drv(1, 1, 7, 1, 0, 0, 9, "prio");
        check("prio.count", int'(count_out), 0);

        // Mid-count async reset
        drv(0, 0, 0, 1, 0, 0, 9, "pre_rst");
        drv(0, 0, 0, 1, 0, 0, 9, "pre_rst");
        async_reset("async_rst");
        drv(0, 0, 0, 1, 0, 0, 9, "post_rst");

        // Load above terminal then step wraps to 1
        drv(0, 1, 9, 0, 0, 0, 5, "hi_load");
        drv(0, 0, 0, 1, 0, 0, 5, "hi_step");
        check("hi.count", int'(count_out), 1);
        drv(0, 0, 0, 1, 0, 0, 5, "hi_after");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            clear        = ($urandom_range(0, 31) == 0);
            load         = ($urandom_range(0, 15) == 0);
            load_val     = N'($urandom_range(0, 15));
            count_enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) count_dir = ~count_dir;
            if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) rollover_val = N'($urandom_range(0, 15));
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
